vga_pattern_gen: RTL and testbench

- Pixel-colour stage directly downstream of the VGA timing generator.
- Consumes the generator's disp_ena/col/row and produces a registered 9-bit RGB pixel plus an aligned data-enable.
- Selects among four test patterns.
- Mode changes requested over a req/ack handshake are applied only at frame boundaries, so no frame is ever torn.

---
 rtl/vga_pkg.sv | 26 ++
 rtl/vga_mode_ctrl.sv | 101 ++++++++++
 rtl/vga_pattern_gen.sv | 96 +++++++++
 tb/tb_vga_pattern_gen.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared modes, colours and visible-area constants for the VGA pixel path
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_SOLID  = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_CHECK  = 2'd2,
        MODE_SCROLL = 2'd3
    } mode_t;

    localparam int RGB_W = 9;

    localparam logic [RGB_W-1:0] WHITE = 9'h1FF;
    localparam logic [RGB_W-1:0] BLACK = 9'h000;
    localparam logic [RGB_W-1:0] BLUE  = 9'h007;
    localparam logic [RGB_W-1:0] RED   = 9'h1C0;

    localparam int VIS_H = 50;
    localparam int VIS_V = 25;

    // Each bar index bit drives one full colour channel: {r, g, b}.
    function automatic logic [RGB_W-1:0] bar_colour(input logic [2:0] idx);
        return {{3{idx[2]}}, {3{idx[1]}}, {3{idx[0]}}};
    endfunction

endpackage

// File: rtl/vga_mode_ctrl.sv
// rtl/vga_mode_ctrl.sv - frame-start detection, frame/scroll counters and frame-aligned mode handshake
module vga_mode_ctrl
    import vga_pkg::*;
#(
    parameter int H_BITS   = 7,
    parameter int V_BITS   = 5,
    parameter int H_PIXELS = VIS_H,
    parameter int BAR_W    = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_ena,
    input  logic [H_BITS-1:0] col,
    input  logic [V_BITS-1:0] row,
    input  logic              mode_req,
    input  logic [1:0]        mode_sel,
    output mode_t             mode_now,
    output logic [H_BITS-1:0] scroll_now,
    output logic              mode_ack,
    output logic              busy,
    output logic [1:0]        cur_mode,
    output logic [7:0]        frame_cnt
);

    typedef enum logic {ST_IDLE, ST_PENDING} state_t;

    localparam logic [H_BITS-1:0] SCROLL_LAST = H_BITS'(H_PIXELS - BAR_W);

    state_t            state, state_n;
    mode_t             pending, pending_n;
    mode_t             mode_q, mode_n;
    logic              ack_n;
    logic              prev_ena;
    logic [H_BITS-1:0] scroll_pos, scroll_n;
    logic              frame_start;

    assign frame_start = disp_ena & ~prev_ena & (col == '0) & (row == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            pending    <= MODE_SOLID;
            mode_q     <= MODE_SOLID;
            mode_ack   <= 1'b0;
            prev_ena   <= 1'b0;
            scroll_pos <= '0;
            frame_cnt  <= 8'd0;
        end else begin
            state      <= state_n;
            pending    <= pending_n;
            mode_q     <= mode_n;
            mode_ack   <= ack_n;
            prev_ena   <= disp_ena;
            scroll_pos <= scroll_n;
            if (frame_start) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // A request arriving on a frame-start cycle is always held for the following frame.
    always_comb begin
        state_n   = state;
        pending_n = pending;
        mode_n    = mode_q;
        ack_n     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mode_req) begin
                    pending_n = mode_t'(mode_sel);
                    state_n   = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (frame_start) begin
                    mode_n  = pending;
                    ack_n   = 1'b1;
                    state_n = ST_IDLE;
                end
                if (mode_req) begin
                    pending_n = mode_t'(mode_sel);
                    state_n   = ST_PENDING;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        scroll_n = scroll_pos;
        if (frame_start) begin
            scroll_n = (scroll_pos == SCROLL_LAST) ? '0 : scroll_pos + H_BITS'(1);
        end
    end

    assign mode_now   = mode_n;
    assign scroll_now = scroll_n;
    assign busy       = (state == ST_PENDING);
    assign cur_mode   = mode_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// rtl/vga_pattern_gen.sv - four-mode test-pattern pixel stage; PATTERN_BORDER_EN adds a red frame border
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int H_BITS    = 7,
    parameter int V_BITS    = 5,
    parameter int H_PIXELS  = VIS_H,
    parameter int V_PIXELS  = VIS_V,
    parameter int BAR_W     = 7,
    parameter int CHK_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              disp_ena,
    input  logic [H_BITS-1:0] col,
    input  logic [V_BITS-1:0] row,
    input  logic              mode_req,
    input  logic [1:0]        mode_sel,
    input  logic [RGB_W-1:0]  solid_rgb,
    output logic              mode_ack,
    output logic              busy,
    output logic [1:0]        cur_mode,
    output logic [7:0]        frame_cnt,
    output logic              de_out,
    output logic [RGB_W-1:0]  rgb
);

    mode_t             mode_now;
    logic [H_BITS-1:0] scroll_now;
    logic [H_BITS-1:0] bar_q;
    logic [2:0]        bar_idx;
    logic [H_BITS:0]   col_ext, scroll_ext;
    logic              in_scroll_bar;
    logic              active;
    logic [RGB_W-1:0]  pix;

    vga_mode_ctrl #(
        .H_BITS   (H_BITS),
        .V_BITS   (V_BITS),
        .H_PIXELS (H_PIXELS),
        .BAR_W    (BAR_W)
    ) u_mode_ctrl (
        .clk        (clk),
        .rst        (rst),
        .disp_ena   (disp_ena),
        .col        (col),
        .row        (row),
        .mode_req   (mode_req),
        .mode_sel   (mode_sel),
        .mode_now   (mode_now),
        .scroll_now (scroll_now),
        .mode_ack   (mode_ack),
        .busy       (busy),
        .cur_mode   (cur_mode),
        .frame_cnt  (frame_cnt)
    );

    assign bar_q   = col / H_BITS'(BAR_W);
    assign bar_idx = (bar_q > H_BITS'(7)) ? 3'd7 : bar_q[2:0];

    // One extra bit so scroll_pos+BAR_W never wraps back into the bar.
    assign col_ext       = {1'b0, col};
    assign scroll_ext    = {1'b0, scroll_now};
    assign in_scroll_bar = (col_ext >= scroll_ext) && (col_ext < scroll_ext + (H_BITS+1)'(BAR_W));

    // Coordinates outside the visible window only come from a misconfigured generator; keep them black.
    assign active = disp_ena && (col < H_BITS'(H_PIXELS)) && (row < V_BITS'(V_PIXELS));

    always_comb begin
        pix = BLACK;
        case (mode_now)
            MODE_SOLID:  pix = solid_rgb;
            MODE_BARS:   pix = bar_colour(bar_idx);
            MODE_CHECK:  pix = (col[CHK_SHIFT] ^ row[CHK_SHIFT]) ? WHITE : BLACK;
            MODE_SCROLL: pix = in_scroll_bar ? WHITE : BLUE;
            default:     pix = BLACK;
        endcase
`ifdef PATTERN_BORDER_EN
        if ((col == '0) || (col == H_BITS'(H_PIXELS - 1)) ||
            (row == '0) || (row == V_BITS'(V_PIXELS - 1))) begin
            pix = RED;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb    <= BLACK;
            de_out <= 1'b0;
        end else begin
            rgb    <= active ? pix : BLACK;
            de_out <= disp_ena;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// tb/tb_vga_pattern_gen.sv - self-checking bench for vga_pattern_gen against a frame-level reference model
module tb_vga_pattern_gen;

    localparam int H_TOT = 54;
    localparam int V_TOT = 27;
    localparam int VIS_W = 50;
    localparam int VIS_R = 25;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       disp_ena = 1'b0;
    logic [6:0] col = 7'd0;
    logic [4:0] row = 5'd0;
    logic       mode_req = 1'b0;
    logic [1:0] mode_sel = 2'd0;
    logic [8:0] solid_rgb = 9'd0;
    logic       mode_ack;
    logic       busy;
    logic [1:0] cur_mode;
    logic [7:0] frame_cnt;
    logic       de_out;
    logic [8:0] rgb;

    int checks = 0;
    int passed = 0;
    int acks   = 0;

    // Reference model state
    int         m_mode, m_pend, m_scroll;
    bit         m_pv, m_prev;
    logic [7:0] m_cnt;
    logic [21:0] exp_vec;

    vga_pattern_gen dut (
        .clk       (clk),
        .rst       (rst),
        .disp_ena  (disp_ena),
        .col       (col),
        .row       (row),
        .mode_req  (mode_req),
        .mode_sel  (mode_sel),
        .solid_rgb (solid_rgb),
        .mode_ack  (mode_ack),
        .busy      (busy),
        .cur_mode  (cur_mode),
        .frame_cnt (frame_cnt),
        .de_out    (de_out),
        .rgb       (rgb)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] model_pix(input int mode, input int c, input int r,
                                             input int s, input logic [8:0] solid);
        int idx;
        int p;
        p = 0;
        case (mode)
            0: p = solid;
            1: begin
                idx = c / 7;
                if (idx > 7) idx = 7;
                p = ((idx >> 2) & 1) * 'h1C0 + ((idx >> 1) & 1) * 'h038 + (idx & 1) * 'h007;
            end
            2: p = (((c >> 2) ^ (r >> 2)) & 1) ? 'h1FF : 0;
            default: p = (c >= s && c < s + 7) ? 'h1FF : 'h007;
        endcase
`ifdef PATTERN_BORDER_EN
        if (c == 0 || c == VIS_W - 1 || r == 0 || r == VIS_R - 1) p = 'h1C0;
`endif
        return 9'(p);
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_scroll = 0; m_pv = 0; m_prev = 0; m_cnt = 8'd0;
    endtask

    task automatic drive_cycle(input bit ena, input int c, input int r, input bit req, input int sel);
        bit fs;
        bit ack;
        @(negedge clk);
        disp_ena = ena; col = 7'(c); row = 5'(r); mode_req = req; mode_sel = 2'(sel);
        fs  = ena && !m_prev && c == 0 && r == 0;
        ack = 0;
        if (fs) begin
            m_cnt    = m_cnt + 8'd1;
            m_scroll = (m_scroll == VIS_W - 7) ? 0 : m_scroll + 1;
            if (m_pv) begin
                m_mode = m_pend; m_pv = 0; ack = 1;
            end
        end
        if (req) begin
            m_pend = sel; m_pv = 1;
        end
        m_prev  = ena;
        exp_vec = {ena ? model_pix(m_mode, c, r, m_scroll, solid_rgb) : 9'h000,
                   ena, ack, m_pv, 2'(m_mode), m_cnt};
        @(posedge clk);
        #1;
        mode_req = 1'b0;
        checks++;
        if ({rgb, de_out, mode_ack, busy, cur_mode, frame_cnt} !== exp_vec)
            $display("FAIL cycle c=%0d r=%0d: got rgb=%h de=%b ack=%b busy=%b mode=%0d cnt=%0d, want rgb=%h de=%b ack=%b busy=%b mode=%0d cnt=%0d",
                     c, r, rgb, de_out, mode_ack, busy, cur_mode, frame_cnt,
                     exp_vec[21:13], exp_vec[12], exp_vec[11], exp_vec[10], exp_vec[9:8], exp_vec[7:0]);
        else
            passed++;
        if (mode_ack) acks++;
    endtask

    task automatic run_frame(input int rc1, input int rr1, input int s1,
                             input int rc2, input int rr2, input int s2);
        for (int r = 0; r < V_TOT; r++) begin
            for (int c = 0; c < H_TOT; c++) begin
                bit hit1, hit2;
                hit1 = (c == rc1 && r == rr1);
                hit2 = (c == rc2 && r == rr2);
                drive_cycle(c < VIS_W && r < VIS_R, c, r, hit1 || hit2, hit2 ? s2 : s1);
            end
        end
    endtask

    task automatic set_mode(input int sel);
        drive_cycle(1'b0, 0, 0, 1'b0, 0);
        drive_cycle(1'b1, 0, 0, 1'b0, 0);
        drive_cycle(1'b1, 1, 1, 1'b1, sel);
        drive_cycle(1'b0, 0, 0, 1'b0, 0);
        drive_cycle(1'b1, 0, 0, 1'b0, 0);
        drive_cycle(1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({rgb, de_out, mode_ack, busy, cur_mode, frame_cnt} !== 22'd0)
            $display("FAIL reset_state: got rgb=%h de=%b ack=%b busy=%b mode=%0d cnt=%0d, want all 0",
                     rgb, de_out, mode_ack, busy, cur_mode, frame_cnt);
        else
            passed++;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_solid();
        solid_rgb = 9'h0AA;
        acks = 0;
        run_frame(-1, -1, 0, -1, -1, 0);
        run_frame(-1, -1, 0, -1, -1, 0);
        checks++;
        if (acks !== 0 || frame_cnt !== 8'd2)
            $display("FAIL solid_frames: got acks=%0d cnt=%0d, want acks=0 cnt=2", acks, frame_cnt);
        else
            passed++;
    endtask

    task automatic test_bars();
        acks = 0;
        run_frame(20, 10, 1, -1, -1, 0);
        checks++;
        if (busy !== 1'b1 || acks !== 0)
            $display("FAIL bars_pending: got busy=%b acks=%0d, want busy=1 acks=0", busy, acks);
        else
            passed++;
        run_frame(-1, -1, 0, -1, -1, 0);
        checks++;
        if (acks !== 1 || cur_mode !== 2'd1 || busy !== 1'b0)
            $display("FAIL bars_ack: got acks=%0d mode=%0d busy=%b, want 1/1/0", acks, cur_mode, busy);
        else
            passed++;
        drive_cycle(1'b1, 0, 0, 1'b0, 0);
        drive_cycle(1'b1, 6, 1, 1'b0, 0);
        checks++;
        if (rgb !== 9'h000) $display("FAIL bars_col6: got %h want 000", rgb); else passed++;
        drive_cycle(1'b1, 7, 1, 1'b0, 0);
        checks++;
        if (rgb !== 9'h007) $display("FAIL bars_col7: got %h want 007", rgb); else passed++;
        drive_cycle(1'b1, 49, 1, 1'b0, 0);
        checks++;
`ifdef PATTERN_BORDER_EN
        if (rgb !== 9'h1C0) $display("FAIL bars_col49: got %h want 1c0", rgb); else passed++;
`else
        if (rgb !== 9'h1FF) $display("FAIL bars_col49: got %h want 1ff", rgb); else passed++;
`endif
        drive_cycle(1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic test_two_reqs();
        int guard;
        acks = 0;
        run_frame(10, 3, 2, 30, 12, 3);
        run_frame(-1, -1, 0, -1, -1, 0);
        checks++;
        if (acks !== 1 || cur_mode !== 2'd3)
            $display("FAIL two_reqs: got acks=%0d mode=%0d, want 1/3", acks, cur_mode);
        else
            passed++;
        guard = 0;
        while (m_scroll != 4 && guard < 60) begin
            drive_cycle(1'b1, 0, 0, 1'b0, 0);
            drive_cycle(1'b0, 0, 0, 1'b0, 0);
            guard++;
        end
        checks++;
        if (m_scroll != 4) $display("FAIL scroll_reach: got guard=%0d want scroll 4 reached", guard);
        else passed++;
        drive_cycle(1'b1, 0, 0, 1'b0, 0);
        drive_cycle(1'b1, 4, 1, 1'b0, 0);
        checks++;
        if (rgb !== 9'h007) $display("FAIL scroll5_col4: got %h want 007", rgb); else passed++;
        drive_cycle(1'b1, 5, 1, 1'b0, 0);
        checks++;
        if (rgb !== 9'h1FF) $display("FAIL scroll5_col5: got %h want 1ff", rgb); else passed++;
        drive_cycle(1'b1, 11, 1, 1'b0, 0);
        checks++;
        if (rgb !== 9'h1FF) $display("FAIL scroll5_col11: got %h want 1ff", rgb); else passed++;
        drive_cycle(1'b1, 12, 1, 1'b0, 0);
        checks++;
        if (rgb !== 9'h007) $display("FAIL scroll5_col12: got %h want 007", rgb); else passed++;
        drive_cycle(1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic test_req_on_fs();
        acks = 0;
        run_frame(0, 0, 1, -1, -1, 0);
        checks++;
        if (acks !== 0 || busy !== 1'b1 || cur_mode !== 2'd3)
            $display("FAIL req_on_fs_same: got acks=%0d busy=%b mode=%0d, want 0/1/3", acks, busy, cur_mode);
        else
            passed++;
        run_frame(-1, -1, 0, -1, -1, 0);
        checks++;
        if (acks !== 1 || cur_mode !== 2'd1)
            $display("FAIL req_on_fs_next: got acks=%0d mode=%0d, want 1/1", acks, cur_mode);
        else
            passed++;
    endtask

    task automatic test_checker();
        set_mode(2);
        drive_cycle(1'b1, 0, 0, 1'b0, 0);
        drive_cycle(1'b1, 4, 0, 1'b0, 0);
        checks++;
`ifdef PATTERN_BORDER_EN
        if (rgb !== 9'h1C0) $display("FAIL check_4_0: got %h want 1c0", rgb); else passed++;
`else
        if (rgb !== 9'h1FF) $display("FAIL check_4_0: got %h want 1ff", rgb); else passed++;
`endif
        drive_cycle(1'b1, 4, 4, 1'b0, 0);
        checks++;
        if (rgb !== 9'h000 || cur_mode !== 2'd2)
            $display("FAIL check_4_4: got rgb=%h mode=%0d want 000/2", rgb, cur_mode);
        else
            passed++;
        drive_cycle(1'b0, 0, 0, 1'b0, 0);
    endtask

    task automatic test_wrap();
        bit cnt_seen, scr_seen;
        bit was255, was43;
        cnt_seen = 0; scr_seen = 0;
        set_mode(3);
        for (int i = 0; i < 300; i++) begin
            was255 = (m_cnt == 8'd255);
            was43  = (m_scroll == VIS_W - 7);
            drive_cycle(1'b1, 0, 0, 1'b0, 0);
            if (was255) begin
                cnt_seen = 1;
                checks++;
                if (frame_cnt !== 8'd0) $display("FAIL cnt_wrap: got %0d want 0", frame_cnt);
                else passed++;
            end
            if (was43) begin
                scr_seen = 1;
                drive_cycle(1'b1, 6, 1, 1'b0, 0);
                checks++;
                if (rgb !== 9'h1FF) $display("FAIL scroll_wrap_col6: got %h want 1ff", rgb); else passed++;
                drive_cycle(1'b1, 7, 1, 1'b0, 0);
                checks++;
                if (rgb !== 9'h007) $display("FAIL scroll_wrap_col7: got %h want 007", rgb); else passed++;
            end
            drive_cycle(1'b1, $urandom_range(1, VIS_W - 1), $urandom_range(0, VIS_R - 1), 1'b0, 0);
            drive_cycle(1'b0, $urandom_range(0, 127), $urandom_range(0, 31), 1'b0, 0);
        end
        checks++;
        if (!cnt_seen || !scr_seen)
            $display("FAIL wrap_seen: got cnt=%b scroll=%b want 1/1", cnt_seen, scr_seen);
        else
            passed++;
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            solid_rgb = 9'($urandom);
            run_frame($urandom_range(0, H_TOT - 1), $urandom_range(0, V_TOT - 1), $urandom_range(0, 3),
                      $urandom_range(0, H_TOT - 1), $urandom_range(0, V_TOT - 1), $urandom_range(0, 3));
        end
        run_frame(-1, -1, 0, -1, -1, 0);
    endtask

    task automatic test_reset_mid();
        solid_rgb = 9'h155;
        drive_cycle(1'b1, 0, 0, 1'b0, 0);
        drive_cycle(1'b1, 1, 0, 1'b1, 2);
        for (int c = 2; c <= 20; c++) drive_cycle(1'b1, c, 0, 1'b0, 0);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        checks++;
        if ({rgb, de_out, mode_ack, busy, cur_mode, frame_cnt} !== 22'd0)
            $display("FAIL async_reset: got rgb=%h de=%b ack=%b busy=%b mode=%0d cnt=%0d, want all 0",
                     rgb, de_out, mode_ack, busy, cur_mode, frame_cnt);
        else
            passed++;
        @(posedge clk);
        #2;
        rst = 1'b1;
        acks = 0;
        for (int c = 21; c < H_TOT; c++) drive_cycle(c < VIS_W, c, 0, 1'b0, 0);
        run_frame(-1, -1, 0, -1, -1, 0);
        checks++;
        if (acks !== 0 || cur_mode !== 2'd0 || frame_cnt !== 8'd1)
            $display("FAIL post_reset: got acks=%0d mode=%0d cnt=%0d, want 0/0/1", acks, cur_mode, frame_cnt);
        else
            passed++;
    endtask

    initial begin
        test_reset();
        test_solid();
        test_bars();
        test_two_reqs();
        test_req_on_fs();
        test_checker();
        test_wrap();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
